// File: rtl/cnn_accel_csr.sv
// MMIO control/status block for the CNN accelerator. It holds the job configuration,
// runs the start/run/done handshake with the engine, and owns the watchdog and the interrupt.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no job in flight; START launches a job
// RUN   | engine busy; leaves on eng_done, watchdog expiry or SOFT_RST
module cnn_accel_csr #(
   parameter logic [31:0] VERSION = 32'h0001_0000,
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mmio_write_en,
   input  logic        mmio_read_en,
   input  logic [31:0] mmio_addr,
   input  logic [31:0] mmio_wdata,
   output logic [31:0] mmio_rdata,
   output logic        intr,
   output logic        eng_start,
   output logic        eng_abort,
   input  logic        eng_done,
   output logic [31:0] cfg_src_addr,
   output logic [31:0] cfg_dst_addr,
   output logic [31:0] cfg_wgt_addr,
   output logic [31:0] cfg_dims
);

   localparam logic [31:0] TMO      = 32'(TIMEOUT);
   localparam logic [31:0] TMO_LOAD = TMO - 32'd1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [5:0]  idx;
   logic        wr_ctrl, wr_status;
   logic        start_wr, soft_rst;
   logic [2:0]  w1c;
   logic        irq_en;
   logic        st_done, st_err_start, st_err_tmo;
   logic [31:0] cycles;
   logic [31:0] wd_cnt;
   logic        tmo_hit;
   logic        start_go, abort_go;
   logic        set_done, set_err_start, set_err_tmo;
   logic [31:0] rd_mux;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{mmio_addr[31:8], mmio_addr[1:0]};

   assign idx       = mmio_addr[7:2];
   assign wr_ctrl   = mmio_write_en && (idx == 6'd0);
   assign wr_status = mmio_write_en && (idx == 6'd1);
   assign start_wr  = wr_ctrl && mmio_wdata[0];
   assign soft_rst  = wr_ctrl && mmio_wdata[2];
   assign w1c       = wr_status ? mmio_wdata[3:1] : 3'b000;

   // Watchdog is a down-counter loaded at launch; terminal count at zero is the timeout cycle.
   assign tmo_hit = (TMO != 32'd0) && (wd_cnt == 32'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_wr) state_nxt = RUN;
         RUN:  if (eng_done || tmo_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (soft_rst) state_nxt = IDLE;
   end

   // SOFT_RST outranks everything else written in the same cycle.
   always_comb begin
      start_go      = 1'b0;
      set_done      = 1'b0;
      set_err_start = 1'b0;
      set_err_tmo   = 1'b0;
      abort_go      = 1'b0;
      if (state == IDLE) begin
         start_go = start_wr && !soft_rst;
      end else begin
         set_done      = eng_done && !soft_rst;
         set_err_start = start_wr && !soft_rst;
         set_err_tmo   = tmo_hit && !eng_done && !soft_rst;
         abort_go      = set_err_tmo || soft_rst;
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      case (idx)
         6'd0: rd_mux = {30'd0, irq_en, 1'b0};
         6'd1: rd_mux = {28'd0, st_err_tmo, st_err_start, st_done, (state == RUN)};
         6'd2: rd_mux = cfg_src_addr;
         6'd3: rd_mux = cfg_dst_addr;
         6'd4: rd_mux = cfg_wgt_addr;
         6'd5: rd_mux = cfg_dims;
         6'd6: rd_mux = cycles;
         6'd7: rd_mux = VERSION;
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mmio_rdata   <= 32'd0;
         intr         <= 1'b0;
         eng_start    <= 1'b0;
         eng_abort    <= 1'b0;
         cfg_src_addr <= 32'd0;
         cfg_dst_addr <= 32'd0;
         cfg_wgt_addr <= 32'd0;
         cfg_dims     <= 32'd0;
         irq_en       <= 1'b0;
         st_done      <= 1'b0;
         st_err_start <= 1'b0;
         st_err_tmo   <= 1'b0;
         cycles       <= 32'd0;
         wd_cnt       <= 32'd0;
      end else begin
         eng_start <= start_go;
         eng_abort <= abort_go;
         intr      <= irq_en && (st_done || st_err_start || st_err_tmo);

         if (mmio_read_en) mmio_rdata <= rd_mux;

         if (wr_ctrl) irq_en <= mmio_wdata[1];
         if (mmio_write_en && idx == 6'd2) cfg_src_addr <= mmio_wdata;
         if (mmio_write_en && idx == 6'd3) cfg_dst_addr <= mmio_wdata;
         if (mmio_write_en && idx == 6'd4) cfg_wgt_addr <= mmio_wdata;
         if (mmio_write_en && idx == 6'd5) cfg_dims     <= mmio_wdata;

         if (soft_rst) begin
            st_done      <= 1'b0;
            st_err_start <= 1'b0;
            st_err_tmo   <= 1'b0;
         end else begin
            st_done      <= set_done      || (st_done      && !w1c[0]);
            st_err_start <= set_err_start || (st_err_start && !w1c[1]);
            st_err_tmo   <= set_err_tmo   || (st_err_tmo   && !w1c[2]);
         end

         if (soft_rst || start_go)                         cycles <= 32'd0;
         else if (state == RUN && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;

         if (start_go)                          wd_cnt <= TMO_LOAD;
         else if (state == RUN && wd_cnt != 0)  wd_cnt <= wd_cnt - 32'd1;
      end
   end

endmodule
